// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: 256-bit cache line <-> four 64-bit memory bursts, one transaction at a time.
// Define CACHELINE_ADAPTOR_ERR_CHK_EN to add a sticky err_o flag for stray resp_i.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
`ifdef CACHELINE_ADAPTOR_ERR_CHK_EN
  ,
  output logic         err_o
`endif
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [255:0] wbuf;
  logic busy;
  assign busy = state == RD || state == WR;
  assign cnt_n = cnt + 2'd1;
  assign resp_o = state == DONE;
  assign read_o = state == RD;
  assign write_o = state == WR;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (write_i ? WR : read_i ? RD : IDLE) :
              state == DONE ? IDLE :
              (resp_i && cnt == 2'd3) ? DONE : state;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      address_o <= 32'd0;
      line_o    <= 256'd0;
      burst_o   <= 64'd0;
      wbuf      <= 256'd0;
    end else begin
      state <= state_n;
      if (state == IDLE && (read_i || write_i)) begin
        cnt       <= 2'd0;
        address_o <= address_i & 32'hFFFF_FFE0;
      end
      if (state == IDLE && write_i) begin
        wbuf    <= line_i;
        burst_o <= line_i[63:0];
      end
      if (busy && resp_i) cnt <= cnt_n;
      if (state == RD && resp_i) line_o[{cnt, 6'd0} +: 64] <= burst_i;
      // burst_o tracks wbuf[cnt] and keeps the last beat once the write finishes
      if (state == WR && resp_i && cnt != 2'd3) burst_o <= wbuf[{cnt_n, 6'd0} +: 64];
    end
  end
`ifdef CACHELINE_ADAPTOR_ERR_CHK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_o <= 1'b0;
    else if (resp_i && !busy) err_o <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed self-checking bench for cacheline_adaptor.
module tb_cacheline_adaptor;
  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o, read_o, write_o, resp_i;
  logic [63:0]  burst_i, burst_o;
  logic         err_o;
  int n_chk = 0;
  int n_fail = 0;
  cacheline_adaptor dut (
    .clk(clk), .reset_n(reset_n), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
`ifdef CACHELINE_ADAPTOR_ERR_CHK_EN
    , .err_o(err_o)
`endif
  );
`ifndef CACHELINE_ADAPTOR_ERR_CHK_EN
  assign err_o = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Full read: accept, four back-to-back beats, DONE, then drop read_i the cycle after resp_o.
  task automatic do_read(input logic [31:0] addr, input logic [255:0] line);
    address_i = addr;
    read_i = 1'b1;
    step;
    chk("rd_accept", {resp_o, read_o, write_o}, 3'b010);
    chk("rd_addr", address_o, addr & 32'hFFFF_FFE0);
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1;
      burst_i = line[64*i +: 64];
      step;
      chk(i < 3 ? "rd_busy" : "rd_done", {resp_o, read_o, write_o}, i < 3 ? 3'b010 : 3'b100);
    end
    resp_i = 1'b0;
    chk("rd_line", line_o, line);
    chk("rd_addr_hold", address_o, addr & 32'hFFFF_FFE0);
    step;
    read_i = 1'b0;
    chk("rd_idle", {resp_o, read_o, write_o}, 3'b000);
    chk("rd_line_stable", line_o, line);
    step;
    chk("rd_no_repeat", {resp_o, read_o, write_o}, 3'b000);
  endtask
  logic [255:0] line_w, line_r;
  int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
  int k;
  initial begin
    reset_n = 1'b0;
    line_i = '0; address_i = '0; read_i = 0; write_i = 0; burst_i = '0; resp_i = 0;
    repeat (3) step;
    chk("reset_ctl", {resp_o, read_o, write_o, err_o}, 4'b0000);
    chk("reset_data", {address_o, burst_o}, 96'd0);
    chk("reset_line", line_o, 256'd0);
    reset_n = 1'b1;
    step;
    // read of an unaligned address, the held-request case is covered inside do_read
    do_read(32'h8000_0047, {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}});
    // write with stalled beats
    line_w = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
    line_i = line_w;
    address_i = 32'h0000_3FFF;
    write_i = 1'b1;
    step;
    chk("wr_accept", {resp_o, read_o, write_o}, 3'b001);
    chk("wr_addr", address_o, 32'h0000_3FE0);
    chk("wr_beat0", burst_o, line_w[63:0]);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      resp_i = pat[i][0];
      k += pat[i];
      step;
      chk("wr_burst", burst_o, line_w[64*(k < 4 ? k : 3) +: 64]);
      chk(k < 4 ? "wr_busy" : "wr_done", {resp_o, read_o, write_o}, k < 4 ? 3'b001 : 3'b100);
    end
    resp_i = 1'b0;
    step;
    write_i = 1'b0;
    chk("wr_idle", {resp_o, read_o, write_o}, 3'b000);
    chk("wr_burst_hold", burst_o, line_w[255:192]);
    // simultaneous read and write: write first, read accepted right after DONE
    line_i = {4{64'h0123_4567_89AB_CDEF}};
    address_i = 32'h0000_2010;
    read_i = 1'b1;
    write_i = 1'b1;
    step;
    chk("sim_write_first", {resp_o, read_o, write_o}, 3'b001);
    chk("sim_addr", address_o, 32'h0000_2000);
    resp_i = 1'b1;
    repeat (4) step;
    resp_i = 1'b0;
    chk("sim_wr_done", {resp_o, read_o, write_o}, 3'b100);
    step;
    write_i = 1'b0;
    chk("sim_turnaround", {resp_o, read_o, write_o}, 3'b000);
    do_read(32'h0000_2010, {64'hFEED_0000_0000_0004, 64'hFEED_0000_0000_0003,
                            64'hFEED_0000_0000_0002, 64'hFEED_0000_0000_0001});
    // stray memory response while idle
    resp_i = 1'b1;
    step;
    resp_i = 1'b0;
    chk("stray_ctl", {resp_o, read_o, write_o}, 3'b000);
`ifdef CACHELINE_ADAPTOR_ERR_CHK_EN
    chk("stray_err", err_o, 1'b1);
`endif
    repeat (2) step;
    chk("stray_ctl_later", {resp_o, read_o, write_o}, 3'b000);
`ifdef CACHELINE_ADAPTOR_ERR_CHK_EN
    chk("stray_err_sticky", err_o, 1'b1);
`endif
    // reset in the middle of a read after two beats
    address_i = 32'h0000_1000;
    read_i = 1'b1;
    step;
    resp_i = 1'b1;
    burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    repeat (2) step;
    chk("mid_rd_partial", line_o[127:0], {2{64'hBAD0_BAD0_BAD0_BAD0}});
    reset_n = 1'b0;
    #1;
    chk("rst_ctl", {resp_o, read_o, write_o, err_o}, 4'b0000);
    chk("rst_data", {address_o, burst_o}, 96'd0);
    chk("rst_line", line_o, 256'd0);
    resp_i = 1'b0;
    read_i = 1'b0;
    step;
    reset_n = 1'b1;
    step;
    chk("rst_idle", {resp_o, read_o, write_o}, 3'b000);
    line_r = {64'h0000_0000_0000_00D4, 64'h0000_0000_0000_00C3,
              64'h0000_0000_0000_00B2, 64'h0000_0000_0000_00A1};
    do_read(32'h0000_1000, line_r);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Burst converter between the L1 cache controller's physical-memory port and the 64-bit burst memory interface. It sits directly downstream of the cache control FSM, which issues whole-line `pmem_read`/`pmem_write` requests. It turns each 256-bit line transfer into four 64-bit beats, and returns a single one-cycle response once all four beats have completed. It buffers one line in each direction and handles one transaction at a time.

## Interface
- Parameters: none (line 256 b, burst 64 b, 4 beats, address 32 b are fixed).
- Clock and reset: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `line_i`  in  256  write line from the cache datapath.
- `line_o`  out  256  read line to the cache datapath.
- `address_i`  in  32  line address from the cache.
- `read_i`  in  1  line read request (cache `pmem_read`).
- `write_i`  in  1  line write request (cache `pmem_write`).
- `resp_o`  out  1  line transfer done (cache `pmem_resp`).
- `burst_i`  in  64  read beat from memory.
- `burst_o`  out  64  write beat to memory.
- `address_o`  out  32  line-aligned memory address.
- `read_o`  out  1  memory read request.
- `write_o`  out  1  memory write request.
- `resp_i`  in  1  memory beat accepted/valid.

## Operation
- **States:** IDLE, RD, WR, DONE. A 2-bit beat counter `cnt` tracks progress.
- **IDLE:**
  - `write_i` → WR. Write has priority if `write_i` and `read_i` are high together.
  - Else `read_i` → RD.
  - On acceptance: latch `address_i & 32'hFFFF_FFE0` into `address_o`; latch `line_i` into the write buffer (write only); clear `cnt`.
  - `resp_i` seen in IDLE is ignored.
- **RD:**
  - `read_o`=1.
  - Each cycle with `resp_i`=1: store `burst_i` into `line_o[64*cnt +: 64]` and increment `cnt`.
  - On the beat with `cnt`==3: → DONE.
- **WR:**
  - `write_o`=1.
  - `burst_o` = write buffer `[64*cnt +: 64]`.
  - Each `resp_i` increments `cnt`.
  - On `cnt`==3 with `resp_i`: → DONE.
- **DONE:** `resp_o`=1 for exactly one cycle, then → IDLE unconditionally.
- **Beats:** need not be consecutive. `resp_i` low in RD/WR holds `cnt` and all data.
- **Request hold:**
  - Upstream holds `read_i`/`write_i` and `address_i` until it sees `resp_o`, and drops them the cycle after.
  - The adaptor samples requests only in IDLE, so no duplicate transaction is started.
- **`line_o`:**
  - Partial beats are visible during RD.
  - The complete line is stable from the DONE cycle until the first beat of the next read.
- **`burst_o`:** holds its last value outside WR.
- **Reset:** asynchronous, any state.
  - Returns to IDLE and clears `cnt`.
  - All outputs go to 0: `resp_o`, `read_o`, `write_o`, `address_o`, `burst_o`, `line_o`.
  - An aborted transaction is dropped. No response is issued.

## Timing
- **Request acceptance:** request seen in IDLE at cycle 0 → `read_o`/`write_o` high from cycle 1.
- **Latency:** back-to-back `resp_i` at cycles k..k+3 → `resp_o` at cycle k+4. Minimum total latency is 5 cycles after acceptance, plus memory wait.
- **Request lines:** `read_o`/`write_o` drop in the DONE cycle; they are never high simultaneously.
- **Output sourcing:** `address_o` is registered and stable for the whole transaction. `resp_o`, `read_o`, `write_o`, `burst_o` decode from state/`cnt` (Moore).
- **Turnaround:** a new request can be accepted the cycle after DONE, i.e. the cache's writeback-then-fill sequence costs one idle cycle between transactions.

## Configuration
- **`CACHELINE_ADAPTOR_ERR_CHK_EN` defined:**
  - Adds output `err_o` (1 b), sticky.
  - Set on any `resp_i` in IDLE or DONE; cleared only by reset; reset value 0.
  - Normal operation is otherwise unchanged.
- **Undefined:** no `err_o` port; stray `resp_i` is silently ignored.

## Test plan
- **Reset mid-RD:** reset mid-RD after 2 beats → all outputs 0, state IDLE. A following read of 0x0000_1000 fetches a fresh 4 beats with `cnt` starting at 0.
- **Read:** `read_i`, `address_i`=0x8000_0047. Memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  - `address_o`=0x8000_0040 throughout.
  - `resp_o` is a single pulse 1 cycle after the 4th beat.
  - `line_o`=={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- **Write with stalls:** `write_i`, `line_i`=256'h{D,C,B,A beats}; `resp_i` pattern 1,0,0,1,1,0,1.
  - `burst_o` steps A→B→C→D only on `resp_i` cycles.
  - `resp_o` fires once, after the 4th accept.
  - `read_o` stays 0 throughout.
- **Simultaneous requests:** `read_i` and `write_i` high together → write transaction first (`write_o`=1, `read_o`=0). Then the read is accepted the cycle after DONE, reusing the same `address_o`.
- **Request held through `resp_o`:** `read_i` held one extra cycle past `resp_o` (dropped on the following edge) → exactly one transaction; `read_o` never reasserts.
- **Stray response (macro defined):** `resp_i` pulsed while IDLE → `err_o` rises next cycle and stays 1 until reset. Without the macro the same stimulus causes no state change.
